// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receive and transmit paths:
// frame width, default baud divider, FSM state encoding and parity helper.
package uart_pkg;

    localparam int DATA_W       = 8;
    localparam int BAUD_DIV_DEF = 5208;
    localparam int HALF_DIV_DEF = BAUD_DIV_DEF / 2;

    localparam logic [2:0] ST_IDLE_ENC   = 3'd0;
    localparam logic [2:0] ST_START_ENC  = 3'd1;
    localparam logic [2:0] ST_DATA_ENC   = 3'd2;
    localparam logic [2:0] ST_PARITY_ENC = 3'd3;
    localparam logic [2:0] ST_STOP_ENC   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = ST_IDLE_ENC,
        ST_START  = ST_START_ENC,
        ST_DATA   = ST_DATA_ENC,
        ST_PARITY = ST_PARITY_ENC,
        ST_STOP   = ST_STOP_ENC
    } uart_state_e;

    // Even parity: the parity bit that makes the total count of ones even.
    function automatic logic parity_even(input logic [DATA_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_rx_core_if.sv
// Receive-side bundle: the serial pin plus the parallel byte, strobe and status
// presented to user logic. The slave modport is the receiver's view.
interface uart_rx_core_if
    import uart_pkg::*;
#(
    parameter int DW = DATA_W
);

    logic          rx_serial;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          rx_parity_err;
    logic          rx_frame_err;
    logic          rx_busy;

    modport slave (
        input  rx_serial,
        output rx_data,
        output rx_valid,
        output rx_parity_err,
        output rx_frame_err,
        output rx_busy
    );

    modport master (
        output rx_serial,
        input  rx_data,
        input  rx_valid,
        input  rx_parity_err,
        input  rx_frame_err,
        input  rx_busy
    );

endinterface

// File: rtl/uart_rx_sync.sv
// Brings the asynchronous serial pin into the clock domain and flags falling edges.
// All flops reset to 1 so an idle line never looks like a start edge after reset.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx_serial_i,
    output logic rx_s_o,
    output logic fall_edge_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= rx_serial_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rx_s_o      = sync_q;
    // Requiring prev_q high keeps a held-low (break) line from re-triggering.
    assign fall_edge_o = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: start/8 data LSB first/even parity/stop, centre-sampled off a
// baud down-to-tick counter, delivering the byte with a one-cycle valid strobe.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  ST_IDLE   | line idle, waiting for a falling edge on the synchronised line
//  ST_START  | counting to the start-bit centre; high there means glitch
//  ST_DATA   | sampling DATA_W data bits, one per baud period, LSB first
//  ST_PARITY | sampling the parity bit
//  ST_STOP   | sampling the stop bit, then publishing byte and error flags
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEF,
    parameter int HALF_DIV = BAUD_DIV / 2
)(
    input  logic             clk,
    input  logic             rst,
    uart_rx_core_if.slave    rx_if
);

    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);

    logic rx_s;
    logic fall_edge;

    uart_rx_sync u_sync (
        .clk         (clk),
        .rst         (rst),
        .rx_serial_i (rx_if.rx_serial),
        .rx_s_o      (rx_s),
        .fall_edge_o (fall_edge)
    );

    uart_state_e       state_q,     state_d;
    logic [CNT_W-1:0]  baud_cnt_q,  baud_cnt_d;
    logic [BIT_W-1:0]  bit_cnt_q,   bit_cnt_d;
    logic [DATA_W-1:0] shreg_q,     shreg_d;
    logic              par_bit_q,   par_bit_d;
    logic [DATA_W-1:0] rx_data_q,   rx_data_d;
    logic              rx_valid_q,  rx_valid_d;
    logic              par_err_q,   par_err_d;
    logic              frm_err_q,   frm_err_d;
    logic              rx_busy_q,   rx_busy_d;

    logic baud_tick;
    logic half_tick;

    assign baud_tick = (baud_cnt_q == BAUD_LAST);
    assign half_tick = (baud_cnt_q == HALF_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            par_bit_q  <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            rx_busy_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            par_bit_q  <= par_bit_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            par_err_q  <= par_err_d;
            frm_err_q  <= frm_err_d;
            rx_busy_q  <= rx_busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q + 1'b1;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        par_bit_d  = par_bit_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        par_err_d  = par_err_q;
        frm_err_d  = frm_err_q;

        unique case (state_q)
            ST_IDLE: begin
                baud_cnt_d = '0;
                bit_cnt_d  = '0;
                if (fall_edge) begin
                    state_d = ST_START;
                end
            end

            ST_START: begin
                if (half_tick) begin
                    baud_cnt_d = '0;
                    state_d    = rx_s ? ST_IDLE : ST_DATA;
                end
            end

            ST_DATA: begin
                if (baud_tick) begin
                    baud_cnt_d = '0;
                    shreg_d    = {rx_s, shreg_q[DATA_W-1:1]};
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = ST_PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end

            ST_PARITY: begin
                if (baud_tick) begin
                    baud_cnt_d = '0;
                    par_bit_d  = rx_s;
                    state_d    = ST_STOP;
                end
            end

            // Leaving at the stop-bit centre leaves half a bit to catch the next start edge.
            ST_STOP: begin
                if (baud_tick) begin
                    baud_cnt_d = '0;
                    rx_data_d  = shreg_q;
                    par_err_d  = parity_even(shreg_q) ^ par_bit_q;
                    frm_err_d  = ~rx_s;
                    rx_valid_d = 1'b1;
                    state_d    = ST_IDLE;
                end
            end

            default: begin
                baud_cnt_d = '0;
                state_d    = ST_IDLE;
            end
        endcase

        rx_busy_d = (state_d != ST_IDLE);
    end

    assign rx_if.rx_data       = rx_data_q;
    assign rx_if.rx_valid      = rx_valid_q;
    assign rx_if.rx_parity_err = par_err_q;
    assign rx_if.rx_frame_err  = frm_err_q;
    assign rx_if.rx_busy       = rx_busy_q;

endmodule
